// File: rtl/layer_mem_sched.sv
// layer_mem_sched
// Arbiter and sequencer for the shared layer-memory port of the CNN accelerator.
// The conv engine writes layer 0 in raster order. The pool engine reads layer 0
// and writes layer 1. At most one access is granted per cycle. The memory strobes,
// addresses, data and csel are registered. A layer-0 read is withheld until its
// address has been written.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   start / busy / done / err      frame control, status, sticky raster-order error
//   conv_req/addr/wdata, conv_gnt  layer-0 writer (transfer = req & gnt)
//   pool_req/rw/addr/wdata, pool_gnt
//                                  pool access: rw=0 reads L0, rw=1 writes L1
//   pool_rdata, pool_rvalid        L0 read return, two cycles after the grant
//   cwr, crd, caddr_wr, caddr_rd, cdata_wr, cdata_rd, csel
//                                  shared memory port
module layer_mem_sched #(
    parameter int unsigned AW       = 12,
    parameter int unsigned DW       = 20,
    parameter int unsigned L0_DEPTH = 4096,
    parameter int unsigned L1_DEPTH = 1024,
    parameter int unsigned STARVE   = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic          conv_req,
    input  logic [AW-1:0] conv_addr,
    input  logic [DW-1:0] conv_wdata,
    output logic          conv_gnt,
    input  logic          pool_req,
    input  logic          pool_rw,
    input  logic [AW-1:0] pool_addr,
    input  logic [DW-1:0] pool_wdata,
    output logic          pool_gnt,
    output logic [DW-1:0] pool_rdata,
    output logic          pool_rvalid,
    output logic          cwr,
    output logic          crd,
    output logic [AW-1:0] caddr_wr,
    output logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_wr,
    input  logic [DW-1:0] cdata_rd,
    output logic [2:0]    csel
);

    localparam int unsigned WCW  = $clog2(L0_DEPTH + 1);
    localparam int unsigned LCW  = $clog2(L1_DEPTH + 1);
    localparam int unsigned SW   = $clog2(STARVE + 1);
    localparam int unsigned L1AW = $clog2(L1_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t         state_q;
    logic [WCW-1:0] wr_cnt_q, wr_cnt_d;
    logic [LCW-1:0] l1_cnt_q, l1_cnt_d;
    logic [SW-1:0]  starve_q, starve_d;
    logic           run, conv_elig, pool_elig, pool_rd_gnt, pool_wr_gnt;

    always_comb begin
        run       = (state_q == RUN);
        conv_elig = conv_req && (wr_cnt_q < WCW'(L0_DEPTH));
        // A read may only target an address whose write has already been counted.
        if (pool_rw) pool_elig = pool_req && (l1_cnt_q < LCW'(L1_DEPTH));
        else         pool_elig = pool_req && (32'(pool_addr) < 32'(wr_cnt_q));
        pool_gnt    = run && pool_elig && (!conv_elig || starve_q == SW'(STARVE));
        conv_gnt    = run && conv_elig && !pool_gnt;
        pool_rd_gnt = pool_gnt && !pool_rw;
        pool_wr_gnt = pool_gnt && pool_rw;

        wr_cnt_d = wr_cnt_q;
        l1_cnt_d = l1_cnt_q;
        if (state_q == FINISH) begin
            wr_cnt_d = '0;
            l1_cnt_d = '0;
        end else begin
            // A grant implies the count is below its depth, so this saturates.
            if (conv_gnt)    wr_cnt_d = wr_cnt_q + WCW'(1);
            if (pool_wr_gnt) l1_cnt_d = l1_cnt_q + LCW'(1);
        end

        starve_d = '0;
        if (run && pool_elig && !pool_gnt) starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            l1_cnt_q    <= '0;
            starve_q    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cwr         <= 1'b0;
            crd         <= 1'b0;
            csel        <= 3'b000;
            caddr_wr    <= '0;
            caddr_rd    <= '0;
            cdata_wr    <= '0;
            pool_rvalid <= 1'b0;
            pool_rdata  <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            l1_cnt_q <= l1_cnt_d;
            starve_q <= starve_d;

            cwr <= conv_gnt || pool_wr_gnt;
            crd <= pool_rd_gnt;
            if (conv_gnt || pool_rd_gnt) csel <= 3'b001;
            else if (pool_wr_gnt)        csel <= 3'b011;
            else                         csel <= 3'b000;

            if (conv_gnt) begin
                caddr_wr <= conv_addr;
                cdata_wr <= conv_wdata;
            end else if (pool_wr_gnt) begin
                caddr_wr <= AW'(pool_addr[L1AW-1:0]);
                cdata_wr <= pool_wdata;
            end
            if (pool_rd_gnt) caddr_rd <= pool_addr;

            // Read data is captured at the end of the crd cycle.
            pool_rvalid <= crd;
            if (crd) pool_rdata <= cdata_rd;

            if (conv_gnt && conv_addr != wr_cnt_q[AW-1:0]) err <= 1'b1;

            case (state_q)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (wr_cnt_q == WCW'(L0_DEPTH) && l1_cnt_q == LCW'(L1_DEPTH)) begin
                        state_q <= FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_mem_sched.sv
// tb_layer_mem_sched
// Directed bench for layer_mem_sched. A frame-level model predicts grants every
// cycle and the registered memory port / status outputs one cycle later; a
// simple memory array answers cdata_rd. Literal checks pin key timings.
module tb_layer_mem_sched;

    localparam int AW = 12;
    localparam int DW = 20;
    localparam int L0 = 4096;
    localparam int L1 = 1024;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          reset, start, busy, done, err;
    logic          conv_req, conv_gnt, pool_req, pool_rw, pool_gnt, pool_rvalid;
    logic [AW-1:0] conv_addr, pool_addr, caddr_wr, caddr_rd;
    logic [DW-1:0] conv_wdata, pool_wdata, pool_rdata, cdata_wr, cdata_rd;
    logic          cwr, crd;
    logic [2:0]    csel;

    int n_cmp = 0;
    int n_bad = 0;

    layer_mem_sched #(.AW(AW), .DW(DW), .L0_DEPTH(L0), .L1_DEPTH(L1), .STARVE(ST)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
        .conv_req(conv_req), .conv_addr(conv_addr), .conv_wdata(conv_wdata), .conv_gnt(conv_gnt),
        .pool_req(pool_req), .pool_rw(pool_rw), .pool_addr(pool_addr), .pool_wdata(pool_wdata),
        .pool_gnt(pool_gnt), .pool_rdata(pool_rdata), .pool_rvalid(pool_rvalid),
        .cwr(cwr), .crd(crd), .caddr_wr(caddr_wr), .caddr_rd(caddr_rd),
        .cdata_wr(cdata_wr), .cdata_rd(cdata_rd), .csel(csel)
    );

    always #5 clk = ~clk;

    // Layer-0 memory behind the port.
    logic [DW-1:0] tbmem [0:L0-1];
    always @(posedge clk) if (cwr && csel == 3'b001) tbmem[caddr_wr] <= cdata_wr;
    assign cdata_rd = crd ? tbmem[caddr_rd] : '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int            m_phase = 0;  // 0 idle, 1 in frame, 2 completion cycle pending
    int            m_wr = 0, m_l1 = 0, m_starve = 0;
    logic          m_err = 1'b0;
    logic [DW-1:0] mdata [0:L0-1];
    logic          e_busy = 0, e_done = 0, e_err = 0, e_cwr = 0, e_crd = 0, e_rvalid = 0;
    logic [2:0]    e_csel = 3'b000;
    logic [AW-1:0] e_caddr_wr = '0, e_caddr_rd = '0;
    logic [DW-1:0] e_cdata_wr = '0, e_rdata = '0, s1_data = '0;

    always @(negedge clk) begin
        logic cel, pel, gp, gc;
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("err", err, e_err);
        chk("cwr", cwr, e_cwr);
        chk("crd", crd, e_crd);
        chk("csel", csel, e_csel);
        chk("pool_rvalid", pool_rvalid, e_rvalid);
        if (e_cwr) begin
            chk("caddr_wr", (e_csel == 3'b011) ? {2'b00, caddr_wr[9:0]} : caddr_wr, e_caddr_wr);
            chk("cdata_wr", cdata_wr, e_cdata_wr);
        end
        if (e_crd) chk("caddr_rd", caddr_rd, e_caddr_rd);
        if (e_rvalid) chk("pool_rdata", pool_rdata, e_rdata);

        cel = conv_req && m_wr < L0;
        pel = pool_req && (pool_rw ? (m_l1 < L1) : (int'(pool_addr) < m_wr));
        gp  = (m_phase == 1) && pel && (!cel || m_starve == ST);
        gc  = (m_phase == 1) && cel && !gp;
        chk("conv_gnt", conv_gnt, gc);
        chk("pool_gnt", pool_gnt, gp);

        if (reset) begin
            m_phase = 0; m_wr = 0; m_l1 = 0; m_starve = 0; m_err = 0;
            e_busy = 0; e_done = 0; e_err = 0; e_cwr = 0; e_crd = 0; e_rvalid = 0;
            e_csel = 3'b000;
        end else begin
            e_rvalid = e_crd;
            e_rdata  = s1_data;
            e_cwr    = gc || (gp && pool_rw);
            e_crd    = gp && !pool_rw;
            e_csel   = (gc || (gp && !pool_rw)) ? 3'b001 : (gp ? 3'b011 : 3'b000);
            if (gc) begin
                e_caddr_wr = conv_addr;
                e_cdata_wr = conv_wdata;
                mdata[conv_addr] = conv_wdata;
                if (int'(conv_addr) != m_wr % L0) m_err = 1'b1;
            end
            if (gp && pool_rw) begin
                e_caddr_wr = pool_addr & 12'h3FF;
                e_cdata_wr = pool_wdata;
            end
            if (gp && !pool_rw) begin
                e_caddr_rd = pool_addr;
                s1_data    = mdata[pool_addr];
            end
            m_starve = ((m_phase == 1) && pel && !gp) ? m_starve + 1 : 0;
            case (m_phase)
                0: if (start) begin m_phase = 1; e_busy = 1; end
                1: if (m_wr == L0 && m_l1 == L1) begin m_phase = 2; e_busy = 0; e_done = 1; end
                default: begin m_phase = 0; e_done = 0; m_wr = 0; m_l1 = 0; end
            endcase
            if (gc) m_wr++;
            if (gp && pool_rw) m_l1++;
            e_err = m_err;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic conv_wr(input int a);
        int n = 0;
        conv_req = 1; conv_addr = AW'(a); conv_wdata = DW'(a);
        #1;
        while (!conv_gnt && n < 50) begin tick(); #1; n++; end
        if (!conv_gnt) chk("conv_wr_timeout", conv_gnt, 1);
        tick();
    endtask

    task automatic pool_wr(input int i);
        int n = 0;
        pool_req = 1; pool_rw = 1; pool_addr = AW'(12'hC00 | i); pool_wdata = DW'(i ^ 'h5A5A5);
        #1;
        while (!pool_gnt && n < 50) begin tick(); #1; n++; end
        if (!pool_gnt) chk("pool_wr_timeout", pool_gnt, 1);
        tick();
    endtask

    initial begin
        int a, pgc, n;
        reset = 1; start = 0; conv_req = 0; conv_addr = '0; conv_wdata = '0;
        pool_req = 0; pool_rw = 0; pool_addr = '0; pool_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0; conv_req = 1;
        #1;
        chk("idle_conv_gnt", conv_gnt, 0);
        chk("idle_cwr", cwr, 0);
        chk("idle_csel", csel, 3'b000);
        chk("idle_busy", busy, 0);
        tick();
        conv_req = 0; start = 1;
        tick();
        start = 0;
        chk("busy_after_start", busy, 1);

        for (int i = 0; i < 64; i++) conv_wr(i);

        // dependency stall on address 64
        conv_req = 0; pool_req = 1; pool_rw = 0; pool_addr = 12'd64;
        repeat (3) begin #1; chk("dep_stall", pool_gnt, 0); tick(); end
        conv_req = 1; conv_addr = 12'd64; conv_wdata = 20'd64;
        #1;
        chk("dep_conv_gnt", conv_gnt, 1);
        chk("dep_pool_held", pool_gnt, 0);
        tick();
        conv_req = 0;
        chk("dep_cwr64", caddr_wr, 12'd64);
        #1;
        chk("dep_pool_gnt", pool_gnt, 1);
        tick();
        pool_req = 0;
        chk("dep_crd", crd, 1);
        chk("dep_caddr_rd", caddr_rd, 12'd64);
        tick();
        chk("dep_rvalid", pool_rvalid, 1);
        chk("dep_rdata", pool_rdata, 20'd64);

        // starvation: conv continuously requesting, pool reads address 5
        a = 65; pgc = 0;
        pool_req = 1; pool_rw = 0; pool_addr = 12'd5; conv_req = 1;
        for (int k = 1; k <= 20 && pgc == 0; k++) begin
            conv_addr = AW'(a); conv_wdata = DW'(a);
            #1;
            if (pool_gnt) pgc = k;
            else if (conv_gnt) a++;
            tick();
        end
        chk("starve_cycle", pgc, 5);
        pool_req = 0; conv_addr = AW'(a); conv_wdata = DW'(a);
        #1;
        chk("conv_regain", conv_gnt, 1);
        a++;
        tick();
        while (a < L0) begin conv_wr(a); a++; end

        // layer 0 complete: conv held requesting must get nothing
        conv_addr = '0;
        #1;
        chk("l0_full_gnt", conv_gnt, 0);
        tick();
        for (int i = 0; i < L1; i++) pool_wr(i);
        chk("l1_last_cwr", cwr, 1);
        chk("l1_last_csel", csel, 3'b011);
        chk("l1_last_addr", caddr_wr[9:0], 10'h3FF);
        #1;
        chk("l1_full_gnt", pool_gnt, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_conv_gnt", conv_gnt, 0);
        tick();
        chk("done_clear", done, 0);
        chk("post_pool_gnt", pool_gnt, 0);
        pool_req = 0; conv_req = 0;
        tick();

        // second frame: raster-order error, then reset mid-frame
        start = 1;
        tick();
        start = 0;
        conv_wr(0);
        conv_wr(1);
        conv_req = 1; conv_addr = 12'd3; conv_wdata = 20'd3;
        #1;
        chk("err_conv_gnt", conv_gnt, 1);
        tick();
        conv_req = 0;
        chk("err_set", err, 1);
        chk("err_write_cwr", cwr, 1);
        chk("err_write_addr", caddr_wr, 12'd3);
        tick();
        conv_wr(3);
        conv_req = 0;
        chk("err_sticky", err, 1);
        pool_req = 1; pool_rw = 0; pool_addr = 12'd0; reset = 1;
        #1;
        chk("rst_read_gnt", pool_gnt, 1);
        tick();
        reset = 0; pool_req = 0;
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_crd", crd, 0);
        conv_req = 1; conv_addr = '0;
        #1;
        chk("rst_no_gnt", conv_gnt, 0);
        tick();
        conv_req = 0;
        chk("rst_rvalid", pool_rvalid, 0);
        n = 0;
        repeat (3) begin tick(); n++; end
        chk("final_idle_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
